// File: rtl/a10s_stream_pkg.sv
// Shared constants and types for the HPS-side frame stream stages.
// Header word layout: magic in the upper half, payload length in the lower half.
package a10s_stream_pkg;

  localparam logic [15:0] FRAME_MAGIC = 16'hA55A;

  localparam int HDR_MAGIC_HI = 31;
  localparam int HDR_MAGIC_LO = 16;
  localparam int HDR_LEN_HI   = 15;
  localparam int HDR_LEN_LO   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } frame_state_t;

endpackage

// File: rtl/st_out_stage.sv
// One-deep valid/ready output register with a ready-latency-0 downstream side.
// The caller may only assert load while load_ok is high.
module st_out_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              load_ok
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // A drain and a reload in the same cycle keep the register full with no bubble.
  assign load_ok = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/a10s_frame_checksum.sv
// Frame parser between the two HPS dual-clock FIFOs: forwards header and payload,
// appends a 32-bit wrap-around word sum as trailer, drops and counts bad headers.
module a10s_frame_checksum
  import a10s_stream_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk_100_clk,
  input  logic             hps_fpga_reset_reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] error_count,
  output logic             busy
);

  localparam logic [31:0] MAX_LEN_U = MAX_LEN;

  frame_state_t     state_q, state_d;
  logic [31:0]      sum_q, sum_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic [CNT_W-1:0] error_count_q, error_count_d;

  logic        rst;
  logic        load_ok;
  logic        load;
  logic [31:0] load_data;
  logic        accept;
  logic [15:0] hdr_len;
  logic        hdr_good;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rst      = hps_fpga_reset_reset;
  assign hdr_len  = in_data[HDR_LEN_HI:HDR_LEN_LO];
  assign hdr_good = (in_data[HDR_MAGIC_HI:HDR_MAGIC_LO] == FRAME_MAGIC) &&
                    ({16'd0, hdr_len} <= MAX_LEN_U);

  // No input is taken in the trailer cycle; the output register is busy with the sum.
  assign in_ready = load_ok && (state_q != TRAILER) && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk_100_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sum_q         <= '0;
      remaining_q   <= '0;
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      remaining_q   <= remaining_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && hdr_good) begin
          state_d = (hdr_len == 16'd0) ? TRAILER : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept && (remaining_q == 16'd1)) begin
          state_d = TRAILER;
        end
      end
      TRAILER: begin
        if (load_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load          = 1'b0;
    load_data     = in_data;
    sum_d         = sum_q;
    remaining_d   = remaining_q;
    frame_count_d = frame_count_q;
    error_count_d = error_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hdr_good) begin
            load        = 1'b1;
            sum_d       = in_data;
            remaining_d = hdr_len;
          end else begin
            error_count_d = sat_inc(error_count_q);
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          load        = 1'b1;
          sum_d       = sum_q + in_data;
          remaining_d = remaining_q - 16'd1;
        end
      end
      TRAILER: begin
        if (load_ok) begin
          load          = 1'b1;
          load_data     = sum_q;
          frame_count_d = sat_inc(frame_count_q);
        end
      end
      default: ;
    endcase
  end

  st_out_stage #(
    .DATA_W(32)
  ) u_out (
    .clk       (clk_100_clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .load_ok   (load_ok)
  );

  assign frame_count = frame_count_q;
  assign error_count = error_count_q;
  assign busy        = (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_a10s_frame_checksum.sv
// Randomized bench for a10s_frame_checksum against a word-list frame parser model.
module tb_a10s_frame_checksum;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;

  logic             clk_100_clk = 1'b0;
  logic             rst;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] error_count;
  logic             busy;

  always #5 clk_100_clk = ~clk_100_clk;

  a10s_frame_checksum #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_100_clk          (clk_100_clk),
    .hps_fpga_reset_reset (rst),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .frame_count          (frame_count),
    .error_count          (error_count),
    .busy                 (busy)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          m_frames = 0;
  int          m_errs   = 0;
  int          low_cnt;
  bit          pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int v);
    int top;
    top = (1 << CNT_W) - 1;
    return (v > top) ? 32'(top) : 32'(v);
  endfunction

  // Parses a whole word list as the upstream stream: headers, payloads, sums.
  function automatic void model(input logic [31:0] w[$]);
    int          i;
    int          len;
    int          take;
    logic [31:0] h;
    logic [31:0] sum;
    i = 0;
    while (i < w.size()) begin
      h = w[i];
      i++;
      len = int'(h[15:0]);
      if (h[31:16] != 16'hA55A || len > MAX_LEN) begin
        m_errs++;
      end else begin
        exp_q.push_back(h);
        sum  = h;
        take = (w.size() - i < len) ? (w.size() - i) : len;
        for (int k = 0; k < take; k++) begin
          exp_q.push_back(w[i]);
          sum = sum + w[i];
          i++;
        end
        if (take == len) begin
          exp_q.push_back(sum);
          m_frames++;
        end
      end
    end
  endfunction

  // mode 0: always ready, mode 1: fixed stall pattern, mode 2: random valid/ready
  task automatic run(input logic [31:0] w[$], input int mode, input int max_cyc);
    int          idx;
    int          cyc;
    int          seen;
    int          total;
    bit          stall;
    logic [31:0] hold;
    idx = 0; cyc = 0; seen = 0; stall = 1'b0; hold = '0;
    model(w);
    total   = exp_q.size();
    low_cnt = 0;
    while ((idx < w.size() || exp_q.size() > 0) && cyc < max_cyc) begin
      @(posedge clk_100_clk);
      #1;
      in_valid = (idx < w.size()) && (mode != 2 || $urandom_range(3) != 0);
      in_data  = in_valid ? w[idx] : $urandom;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 6];
        default: out_ready = ($urandom_range(2) != 0);
      endcase
      @(negedge clk_100_clk);
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, hold);
      end
      stall = out_valid && !out_ready;
      hold  = out_data;
      if (!in_ready) low_cnt++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        seen++;
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
      end
      cyc++;
    end
    chk("timeout", 32'(cyc < max_cyc), 32'd1);
    chk("out_count", 32'(seen), 32'(total));
    exp_q.delete();
    @(posedge clk_100_clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk_100_clk);
    chk("drained", 32'(out_valid), 32'd0);
    chk("frame_count", 32'(frame_count), sat(m_frames));
    chk("error_count", 32'(error_count), sat(m_errs));
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_error_count", 32'(error_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] w[$];
    int          len;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk_100_clk);
    @(negedge clk_100_clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk_100_clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    w = '{32'hA55A0003, 32'd1, 32'd2, 32'd3};
    run(w, 0, 100);
    chk("trailer_stall_cycles", 32'(low_cnt), 32'd1);

    w = '{32'hA55A0000};
    run(w, 0, 100);
    w = '{32'hA55A0001, 32'hFFFFFFFF};
    run(w, 0, 100);

    // Wrong magic, then a length one past MAX_LEN; neither may reach the output.
    w = '{32'h12340002, 32'hA55A0011};
    run(w, 0, 100);
    w = '{32'hA55A0001, 32'd7};
    run(w, 0, 100);

    w = '{32'hA55A0010};
    for (int k = 0; k < MAX_LEN; k++) w.push_back($urandom);
    run(w, 1, 400);

    // Reset after two of five payload words; the frame is left without a trailer.
    w = '{32'hA55A0005, $urandom, $urandom};
    run(w, 0, 100);
    rst = 1'b1;
    @(posedge clk_100_clk);
    @(negedge clk_100_clk);
    check_reset_vals();
    rst = 1'b0;
    m_frames = 0;
    m_errs   = 0;
    @(negedge clk_100_clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    w = '{32'hA55A0003, $urandom, $urandom, $urandom};
    run(w, 2, 400);

    w.delete();
    for (int k = 0; k < 5; k++) w.push_back({16'h5AA5, 16'($urandom_range(0, 65535))});
    run(w, 2, 400);

    for (int f = 0; f < 8; f++) begin
      w.delete();
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(3) == 0) begin
          w.push_back({16'hA55A, 16'($urandom_range(MAX_LEN + 1, 65535))});
        end else begin
          len = $urandom_range(0, MAX_LEN);
          w.push_back({16'hA55A, 16'(len)});
          for (int k = 0; k < len; k++) w.push_back($urandom);
        end
      end
      run(w, 2, 2000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a10s_frame_checksum.md
# a10s_frame_checksum

Avalon-ST frame stage in the FPGA fabric between the two HPS-side dual-clock FIFOs of the `a10s_ghrd` system. It consumes 32-bit words drained from `dc_fifo_0_out`, parses a header word, forwards header and payload unchanged, appends a 32-bit checksum trailer, and feeds the result into `dc_fifo_1_in`. Malformed headers are dropped and counted. Frame and error counters are exported for a status PIO.

## Interface
- `MAX_LEN`, default 1024: largest legal payload length in words. A header with a length above this is an error.
- `CNT_W`, default 16: width of the status counters.
- `clk_100_clk`, in, 1: single clock, the same domain as the FIFO read/write sides.
- `hps_fpga_reset_reset`, in, 1: reset, synchronous, active-high.
- `in_data`, in, 32: stream word; connects to `dc_fifo_0_out_data`.
- `in_valid`, in, 1: connects to `dc_fifo_0_out_valid`.
- `in_ready`, out, 1: connects to `dc_fifo_0_out_ready`.
- `out_data`, out, 32: connects to `dc_fifo_1_in_data`.
- `out_valid`, out, 1: connects to `dc_fifo_1_in_valid`.
- `out_ready`, in, 1: connects to `dc_fifo_1_in_ready`.
- `frame_count`, out, CNT_W: number of trailers emitted; saturates.
- `error_count`, out, CNT_W: number of headers dropped; saturates.
- `busy`, out, 1: high when state ≠ IDLE or `out_valid` is high.

## Operation
- **Header format:** `[31:16]` = MAGIC (0xA55A); `[15:0]` = payload length N (0..MAX_LEN).
- **Handshakes:** Avalon-ST, ready latency 0. A transfer occurs when valid and ready are high on the same clock edge.
- **Output register:** single output register stage. `load_ok = !out_valid || out_ready`.
- **in_ready:** `in_ready = load_ok && state != TRAILER`. It is 0 while reset is asserted.
- **IDLE state**, on accepting a word:
  - Good header (magic matches and N ≤ MAX_LEN): load the word into the output register, set `sum = word`, set `remaining = N`. Go to TRAILER if N = 0, else go to PAYLOAD.
  - Bad header: the word is consumed and not forwarded. `error_count` increments. Stay in IDLE.
- **PAYLOAD state**, on accepting a word:
  - Load the word into the output register.
  - `sum += word`, modulo 2^32 (wrap-around, no carry out).
  - Decrement `remaining`; go to TRAILER when it reaches 0.
- **TRAILER state**, when `load_ok`: load `sum` into the output register, increment `frame_count`, go to IDLE. No input word is accepted in this cycle.
- **Counters:** saturate at all-ones and never wrap.
- **Reset mid-frame:** state goes to IDLE and all registers clear. The partial frame already downstream is left truncated (no trailer). The upstream FIFO is not flushed. The next accepted word is parsed as a header.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `in_ready`=0, `frame_count`=0, `error_count`=0, `busy`=0. State = IDLE, `sum`=0, `remaining`=0.
- **Latency:** a word accepted at edge t is presented on `out_data`/`out_valid` from t+1.
- **Stability:** while `out_valid && !out_ready`, `out_data` holds stable and `out_valid` stays high.
- **Throughput:** 1 word/cycle through header and payload. The trailer costs exactly one cycle with `in_ready`=0. A frame of N payload words therefore occupies N+2 accepted-output cycles.
- **Simultaneous events:** an output drain and a new load in the same cycle are legal and give no bubble.
- **Counter timing:** each counter update is visible one cycle after the causing edge.

## Structure
- **Package `a10s_stream_pkg`:**
  - `FRAME_MAGIC` = 16'hA55A.
  - Header field slice constants (`HDR_MAGIC_HI/LO`, `HDR_LEN_HI/LO`).
  - State enum `frame_state_t {IDLE, PAYLOAD, TRAILER}`.
- **Sub-module `st_out_stage`:** the one-deep valid/ready output register. Inputs: load/data. Outputs: `out_*` and `load_ok`.
- **Top module:** FSM, checksum accumulator, length counter, status counters.

## Test plan
- **Basic frame:** `out_ready`=1; send 0xA55A0003, 1, 2, 3. Required output: 0xA55A0003, 1, 2, 3, 0xA55A0009. `frame_count`=1. `in_ready` low for exactly one cycle at the trailer.
- **Zero length and sum wrap:**
  - Send 0xA55A0000 → output 0xA55A0000, 0xA55A0000.
  - Send 0xA55A0001, 0xFFFFFFFF → trailer 0xA55A0000.
- **Bad headers:** with `MAX_LEN`=4, send 0x12340002 and then 0xA55A0005. Required: no output, `error_count`=2. A following 0xA55A0001, 7 produces trailer 0xA55A0008.
- **Backpressure:** `out_ready` pattern 1,0,0,1,0,1… over a 16-word frame. Required: output sequence identical to the no-stall case, no duplicates or drops, `out_data` stable while stalled.
- **Reset mid-payload:** assert reset for 1 cycle after 2 of 5 payload words. Required: all outputs take their reset values the next cycle. A fresh header is then parsed correctly and the frame gets the correct trailer.
- **Counter saturation:** with `CNT_W`=2, send 5 bad headers → `error_count` holds at 3.
